// File: rtl/kalman_pkg.sv
// kalman_pkg: shared FSM state type, default widths and the saturating covariance adder.
package kalman_pkg;
   typedef enum logic [2:0] {IDLE, PRED, DIV, UPD, OUT} state_t;
   localparam int DEF_PW   = 16;
   localparam int DEF_FRAC = 8;
   localparam int PDW      = DEF_PW + 1;
   localparam int NUMW     = DEF_PW + DEF_FRAC;
   function automatic logic [31:0] sat_add_pw(input logic [31:0] a, input logic [31:0] b, input int w);
      logic [32:0] s;
      logic [32:0] m;
      s = {1'b0, a} + {1'b0, b};
      m = (33'd1 << w) - 33'd1;
      return (s > m) ? m[31:0] : s[31:0];
   endfunction
endpackage

// File: rtl/kalman_div_seq.sv
// kalman_div_seq: restoring divider, one quotient bit per cycle MSB first; needs num[NW-1:QW] < den.
module kalman_div_seq
   import kalman_pkg::*;
#(
   parameter int NW  = NUMW,
   parameter int DNW = PDW,
   parameter int QW  = DEF_FRAC
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start_i,
   input  logic [NW-1:0]  num_i,
   input  logic [DNW-1:0] den_i,
   output logic           busy_o,
   output logic           done_o,
   output logic [QW-1:0]  q_o
);
   localparam int CNW = $clog2(QW + 1);
   logic [DNW-1:0] rem_q, den_q;
   logic [QW-1:0]  lo_q, q_q;
   logic [CNW-1:0] cnt_q;
   logic           busy_q, done_q;
   logic [DNW:0]   t, diff;
   logic           ge;
   always_comb begin
      t    = {rem_q, lo_q[QW-1]};
      diff = t - {1'b0, den_q};
      ge   = t >= {1'b0, den_q};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= '0;
         den_q  <= '0;
         lo_q   <= '0;
         q_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= !start_i && busy_q && cnt_q == CNW'(1);
         if (start_i) begin
            rem_q  <= DNW'(num_i[NW-1:QW]);
            lo_q   <= num_i[QW-1:0];
            den_q  <= den_i;
            q_q    <= '0;
            cnt_q  <= CNW'(QW);
            busy_q <= 1'b1;
         end else if (busy_q) begin
            rem_q  <= ge ? diff[DNW-1:0] : t[DNW-1:0];
            lo_q   <= lo_q << 1;
            q_q    <= {q_q[QW-2:0], ge};
            cnt_q  <= cnt_q - CNW'(1);
            busy_q <= cnt_q != CNW'(1);
         end
      end
   end
   assign busy_o = busy_q;
   assign done_o = done_q;
   assign q_o    = q_q;
endmodule

// File: rtl/kalman_filter_mc.sv
// kalman_filter_mc: time-multiplexed scalar Kalman filter, one estimate/covariance per channel,
// gain from a shared sequential divider.
module kalman_filter_mc
   import kalman_pkg::*;
#(
   parameter int DW   = 12,
   parameter int NCH  = 4,
   parameter int CW   = 2,
   parameter int PW   = 16,
   parameter int FRAC = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [CW-1:0] in_ch_i,
   input  logic [DW-1:0] in_data_i,
   input  logic [PW-1:0] cfg_q_i,
   input  logic [PW-1:0] cfg_r_i,
   input  logic          ch_clr_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [CW-1:0] out_ch_o,
   output logic [DW-1:0] out_data_o,
   output logic          err_ch_o
);
   localparam int PRW = FRAC + DW + 2;
   state_t          state_q, state_d;
   logic [CW-1:0]   ch_q, out_ch_q;
   logic [DW-1:0]   z_q, out_data_q;
   logic [PW-1:0]   qn_q, r_q, pp_q;
   logic            first_q, clr_pend_q, err_q;
   logic [DW-1:0]   x_q [NCH];
   logic [PW-1:0]   p_q [NCH];
   logic [NCH-1:0]  init_q, init_d;
   logic            accept, ch_ok, div_busy, div_done;
   logic [FRAC-1:0] k;
   logic [PW-1:0]   pp_d, pn_c;
   logic [DW-1:0]   x_sel, xn_c;
   logic signed [FRAC:0] ks;
   logic signed [DW:0]   dlt;
   logic signed [PRW-1:0] prod, rnd, xn;
   logic [FRAC:0]         kc;
   logic [PW+FRAC:0]      pm;
   assign in_ready_o  = state_q == IDLE && !out_valid_o;
   assign out_valid_o = state_q == OUT;
   assign accept      = in_valid_i && in_ready_o;
   assign ch_ok       = 32'(in_ch_i) < 32'(NCH);
   assign pp_d        = PW'(sat_add_pw(32'(p_q[ch_q]), 32'(qn_q), PW));
   always_comb begin
      state_d = state_q == IDLE ? ((accept && ch_ok) ? PRED : IDLE)
              : state_q == PRED ? DIV
              : state_q == DIV  ? ((div_busy || !div_done) ? DIV : UPD)
              : state_q == UPD  ? OUT
              : (out_ready_i ? IDLE : OUT);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end
   kalman_div_seq #(.NW(PW + FRAC), .DNW(PW + 1), .QW(FRAC)) u_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .start_i(state_q == PRED),
      .num_i  ({pp_d, {FRAC{1'b0}}}),
      .den_i  ({1'b0, pp_d} + {1'b0, r_q}),
      .busy_o (div_busy),
      .done_o (div_done),
      .q_o    (k)
   );
   // Half-up rounded gain step; the clamp only guards against arithmetic surprises
   always_comb begin
      x_sel = x_q[ch_q];
      ks    = {1'b0, k};
      dlt   = $signed({1'b0, z_q}) - $signed({1'b0, x_sel});
      prod  = PRW'(ks) * PRW'(dlt);
      rnd   = prod + PRW'(2 ** (FRAC - 1));
      xn    = PRW'($signed({1'b0, x_sel})) + (rnd >>> FRAC);
      kc    = (FRAC + 1)'(2 ** FRAC) - {1'b0, k};
      pm    = (PW + FRAC + 1)'(kc) * (PW + FRAC + 1)'(pp_q);
      xn_c  = first_q ? z_q : xn < 0 ? '0 : xn > PRW'(2 ** DW - 1) ? '1 : xn[DW-1:0];
      pn_c  = first_q ? r_q : pm[PW+FRAC-1:FRAC];
   end
   // A clear seen during flight lets the update commit but leaves the channel uninitialised
   always_comb begin
      init_d = ch_clr_i ? '0 : init_q;
      if (state_q == UPD) init_d[ch_q] = !(clr_pend_q || ch_clr_i);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_q       <= '0;
         z_q        <= '0;
         qn_q       <= '0;
         r_q        <= '0;
         pp_q       <= '0;
         first_q    <= 1'b0;
         clr_pend_q <= 1'b0;
         err_q      <= 1'b0;
         out_ch_q   <= '0;
         out_data_q <= '0;
         init_q     <= '0;
         for (int i = 0; i < NCH; i++) begin
            x_q[i] <= '0;
            p_q[i] <= '0;
         end
      end else begin
         err_q      <= accept && !ch_ok;
         clr_pend_q <= accept ? 1'b0 : clr_pend_q || (ch_clr_i && (state_q == PRED || state_q == DIV));
         init_q     <= init_d;
         if (accept) begin
            ch_q    <= in_ch_i;
            z_q     <= in_data_i;
            qn_q    <= cfg_q_i;
            r_q     <= cfg_r_i == '0 ? PW'(1) : cfg_r_i;
            first_q <= ch_clr_i || !init_q[in_ch_i];
         end
         if (state_q == PRED) pp_q <= pp_d;
         if (state_q == UPD) begin
            x_q[ch_q]  <= xn_c;
            p_q[ch_q]  <= pn_c;
            out_ch_q   <= ch_q;
            out_data_q <= xn_c;
         end
      end
   end
   assign out_ch_o   = out_ch_q;
   assign out_data_o = out_data_q;
   assign err_ch_o   = err_q;
endmodule

// File: doc/kalman_filter_mc.md
Name: kalman_filter_mc

Overview:
Multi-channel, parameterised scalar Kalman filter for time-multiplexed ADC sample streams. It holds one estimate and one covariance per channel in internal registers. It computes the Kalman gain with an iterative divider, and moves samples in and out over valid/ready handshakes. It sits between the ADC capture/mux front end and downstream DSP, and replaces the fixed 8-bit single-channel smoother.

Parameters:
DW, 12, sample/estimate width (unsigned)
NCH, 4, number of channels
CW, 2, channel index width; must be >= clog2(NCH)
PW, 16, covariance width (unsigned integer)
FRAC, 8, gain fraction bits; gain K is in [0, 2^FRAC)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  sample valid
in_ready  out  1  block can accept a sample
in_ch  in  CW  channel of the sample
in_data  in  DW  measurement z
cfg_q  in  PW  process noise Q, sampled at accept
cfg_r  in  PW  measurement noise R, sampled at accept; 0 is treated as 1
ch_clr  in  1  one-cycle pulse; clears the init flag of all channels
out_valid  out  1  estimate valid
out_ready  in  1  downstream accepts
out_ch  out  CW  channel of the estimate
out_data  out  DW  filtered estimate
err_ch  out  1  one-cycle pulse: a sample with in_ch >= NCH was dropped

Behaviour:
- Reset is asynchronous, active-low, on clk domain. It sets state IDLE, out_valid=0, out_ch=0, out_data=0, err_ch=0, all per-channel x/P=0 and all init flags=0. in_ready=1 after reset. Reset mid-computation aborts the computation silently.
- in_ready = (state==IDLE) && !out_valid.
- An accept occurs at an edge with in_valid && in_ready. At accept the block latches in_ch, in_data, cfg_q and max(cfg_r,1).
- FSM states: IDLE -> PRED (1 cycle) -> DIV (FRAC cycles) -> UPD (1 cycle) -> OUT -> IDLE.
- OUT holds out_valid until out_ready; the state returns to IDLE at the handshake edge.
- If the accept edge is T, out_valid rises at edge T+FRAC+3 (T+11 at defaults).
- PRED: Pp = saturating(P[ch] + Q), clamped at 2^PW-1. D = Pp + R, computed in PW+1 bits with no overflow.
- DIV: K = floor((Pp << FRAC) / D). This is an unsigned restoring division producing one quotient bit per cycle, MSB first. R >= 1 guarantees K < 2^FRAC.
- UPD for an initialised channel:
  - d = z - x, signed DW+1 bits.
  - x' = x + ((K*d + 2^(FRAC-1)) >>> FRAC), arithmetic shift, i.e. floor after half-up bias.
  - P' = ((2^FRAC - K) * Pp) >> FRAC.
  - x' always lies between x and z, so no clamp is needed. Nonetheless, implement a clamp to [0, 2^DW-1] as a guard.
- UPD for an uninitialised channel: x' = z, P' = R, set the init flag. Latency is unchanged (the divider still runs; its result is discarded).
- x[ch], P[ch] and the init flag are written at the UPD edge. out_data = x' and out_ch = ch are held stable while out_valid && !out_ready.
- in_ch >= NCH: the sample is accepted, err_ch pulses at T+1, no state is changed, no output is produced, and in_ready returns to 1 at T+1.
- ch_clr:
  - ch_clr clears every init flag. x and P are left as-is but become irrelevant.
  - If ch_clr coincides with an accept, the accepted sample is treated as a first sample.
  - If ch_clr arrives while a computation is in flight, the in-flight channel still commits, then its flag is cleared. The in-flight output is still produced.
- Channels are fully independent; other channels' state never changes during an update.

Decomposition:
- Package kalman_pkg holds:
  - the FSM state enum (IDLE, PRED, DIV, UPD, OUT);
  - localparam helpers PDW = PW+1 and NUMW = PW+FRAC;
  - a function sat_add_pw.
- One sub-module, kalman_div_seq: start/busy/done restoring divider, NUMW/PDW in, FRAC-bit quotient, FRAC cycles. The top module instantiates it once, shared across channels.

Test Plan:
All scenarios use default parameters and cfg_q=2, cfg_r=10 unless stated.
- Reset: assert rst_n=0 mid-DIV -> out_valid=0, out_data=0, in_ready=1 immediately after release; the next ch0 sample is treated as first.
- First sample: ch0 z=1000 accepted at T -> out_valid at T+11, out_ch=0, out_data=1000; internal P[0]=10.
- Second ch0 sample z=1100 -> Pp=12, D=22, K=139, out_data=1054, P[0]=5.
- Negative step: ch0 z=0 next -> Pp=7, K=105, out_data=622. Then ch1 z=50 -> out_data=50 (first sample); ch0 state unchanged (next ch0 z=622 gives 622).
- Backpressure: hold out_ready=0 for 5 cycles -> out_valid, out_ch and out_data stable, in_ready=0 while in_valid is high. Release -> one handshake, then in_ready=1 the next cycle.
- Errors/clear: in_ch=5 with CW=3, NCH=4 -> err_ch pulse, no out_valid. ch_clr coinciding with a ch0 accept of z=300 -> out_data=300.
